eth_tx_sched: RTL and testbench

Transmit scheduler for the 10BASE-T transmitter. It shares the single Manchester transmitter between two frame requesters, issues the one-cycle start pulse the transmitter expects, and presents the selected payload length and source. It also enforces the inter-packet gap and watches for a transmitter that fails to start. It sits in the clkTx (20 MHz) domain, between the packet sources (periodic beacon, UDP reply) and the transmitter's start/busy interface.

---
 rtl/eth_tx_sched.sv | 164 ++++++++++++++++
 tb/tb_eth_tx_sched.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/eth_tx_sched.sv
// Transmit scheduler: round-robin arbitration of two frame requesters onto the
// single Manchester transmitter, with inter-packet gap and start-timeout watch.
module eth_tx_sched #(
  parameter int IPG_CYCLES    = 192,
  parameter int START_TIMEOUT = 8,
  parameter int MIN_PAYLOAD   = 18,
  parameter int MAX_PAYLOAD   = 1472
) (
  input  logic        clkTx,
  input  logic        reset,
  input  logic        req0,
  input  logic [10:0] len0,
  input  logic        req1,
  input  logic [10:0] len1,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [10:0] tx_len,
  output logic        tx_sel,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        tx_err,
  output logic [15:0] frames_sent
);

  typedef enum logic [2:0] {IDLE, START, WAIT_BUSY, SENDING, GAP} state_t;

  localparam logic [15:0] IPG_LAST     = 16'(IPG_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(START_TIMEOUT - 1);
  localparam logic [10:0] MIN_LEN      = 11'(MIN_PAYLOAD);
  localparam logic [10:0] MAX_LEN      = 11'(MAX_PAYLOAD);

  state_t      state_q, state_d;
  logic [15:0] timer_q, timer_d;
  logic        ptr_q, ptr_d;
  logic [10:0] txLen_q, txLen_d;
  logic        txSel_q, txSel_d;
  logic        txStart_q, txStart_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        done0_q, done0_d;
  logic        done1_q, done1_d;
  logic        txErr_q, txErr_d;
  logic [15:0] frameCnt_q, frameCnt_d;

  logic        pick;
  logic [10:0] pickLen;
  logic [10:0] clampLen;

  // ptr_q holds the last-served requester, so a tie goes to the other one.
  always_comb begin
    pick     = (req0 && req1) ? ~ptr_q : req1;
    pickLen  = pick ? len1 : len0;
    clampLen = pickLen;
    if (pickLen < MIN_LEN) begin
      clampLen = MIN_LEN;
    end else if (pickLen > MAX_LEN) begin
      clampLen = MAX_LEN;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    ptr_d      = ptr_q;
    txLen_d    = txLen_q;
    txSel_d    = txSel_q;
    txStart_d  = 1'b0;
    gnt0_d     = 1'b0;
    gnt1_d     = 1'b0;
    done0_d    = 1'b0;
    done1_d    = 1'b0;
    txErr_d    = 1'b0;
    frameCnt_d = frameCnt_q;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          txSel_d   = pick;
          ptr_d     = pick;
          txLen_d   = clampLen;
          txStart_d = 1'b1;
          gnt0_d    = ~pick;
          gnt1_d    = pick;
          state_d   = START;
        end
      end
      START: begin
        timer_d = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = SENDING;
        end else if (timer_q == TIMEOUT_LAST) begin
          txErr_d = 1'b1;
          timer_d = '0;
          state_d = GAP;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      SENDING: begin
        if (!tx_busy) begin
          done0_d    = ~txSel_q;
          done1_d    = txSel_q;
          frameCnt_d = frameCnt_q + 16'd1;
          timer_d    = '0;
          state_d    = GAP;
        end
      end
      GAP: begin
        // Requests stay pending here; they are only looked at again in IDLE.
        if (timer_q == IPG_LAST) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkTx) begin
    if (reset) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      ptr_q      <= 1'b1;
      txLen_q    <= '0;
      txSel_q    <= 1'b0;
      txStart_q  <= 1'b0;
      gnt0_q     <= 1'b0;
      gnt1_q     <= 1'b0;
      done0_q    <= 1'b0;
      done1_q    <= 1'b0;
      txErr_q    <= 1'b0;
      frameCnt_q <= '0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      ptr_q      <= ptr_d;
      txLen_q    <= txLen_d;
      txSel_q    <= txSel_d;
      txStart_q  <= txStart_d;
      gnt0_q     <= gnt0_d;
      gnt1_q     <= gnt1_d;
      done0_q    <= done0_d;
      done1_q    <= done1_d;
      txErr_q    <= txErr_d;
      frameCnt_q <= frameCnt_d;
    end
  end

  assign tx_start    = txStart_q;
  assign tx_len      = txLen_q;
  assign tx_sel      = txSel_q;
  assign gnt0        = gnt0_q;
  assign gnt1        = gnt1_q;
  assign done0       = done0_q;
  assign done1       = done1_q;
  assign tx_err      = txErr_q;
  assign frames_sent = frameCnt_q;

endmodule

// File: tb/tb_eth_tx_sched.sv
// Directed bench for eth_tx_sched: a vector table for single grant decisions,
// then hand-written multi-cycle sequences for gap, timeout, reset and wrap.
module tb_eth_tx_sched;

  localparam int IPG = 192;
  localparam int TMO = 8;

  logic        clkTx = 1'b0;
  logic        reset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, tx_busy = 1'b0;
  logic [10:0] len0 = '0, len1 = '0;
  logic        tx_start, tx_sel, gnt0, gnt1, done0, done1, tx_err;
  logic [10:0] tx_len;
  logic [15:0] frames_sent;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  typedef struct {
    logic        r0;
    logic        r1;
    logic [10:0] l0;
    logic [10:0] l1;
    logic        eGnt0;
    logic        eGnt1;
    logic        eStart;
    logic        eSel;
    logic [10:0] eLen;
  } vec_t;

  vec_t vecs[11];

  eth_tx_sched #(
    .IPG_CYCLES(IPG), .START_TIMEOUT(TMO), .MIN_PAYLOAD(18), .MAX_PAYLOAD(1472)
  ) dut (
    .clkTx(clkTx), .reset(reset),
    .req0(req0), .len0(len0), .req1(req1), .len1(len1),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_len(tx_len), .tx_sel(tx_sel),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .tx_err(tx_err), .frames_sent(frames_sent)
  );

  always #5 clkTx = ~clkTx;
  always @(posedge clkTx) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clkTx);
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic applyStimulus(input vec_t v, input int idx);
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0 = v.r0;
    req1 = v.r1;
    len0 = v.l0;
    len1 = v.l1;
    step();
    checkOutput($sformatf("vec%0d", idx),
                {49'd0, gnt0, gnt1, tx_start, tx_sel, tx_len},
                {49'd0, v.eGnt0, v.eGnt1, v.eStart, v.eSel, v.eLen});
    req0 = 1'b0;
    req1 = 1'b0;
  endtask

  task automatic waitStart(input int limit, output int startCyc);
    startCyc = -1;
    for (int i = 0; i < limit; i++) begin
      if (tx_start) begin
        startCyc = cyc;
        break;
      end
      step();
    end
    if (startCyc < 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL startWait: no tx_start within %0d cycles, expected one", limit);
    end
  endtask

  // Transmitter model: busy rises the cycle after tx_start is seen and is held busyLen cycles.
  task automatic runFrame(input int busyLen, output int doneCyc, output logic stray);
    stray = 1'b0;
    step();
    tx_busy = 1'b1;
    for (int i = 0; i < busyLen; i++) begin
      step();
      stray = stray | done0 | done1 | tx_err | tx_start;
    end
    tx_busy = 1'b0;
    step();
    doneCyc = cyc;
  endtask

  initial begin
    int   s, s2, d, prevDone, errCyc, errCnt;
    logic stray, anyDone;

    vecs[0]  = '{1'b0, 1'b0, 11'd0,    11'd0,    1'b0, 1'b0, 1'b0, 1'b0, 11'd0};
    vecs[1]  = '{1'b1, 1'b0, 11'd100,  11'd900,  1'b1, 1'b0, 1'b1, 1'b0, 11'd100};
    vecs[2]  = '{1'b0, 1'b1, 11'd500,  11'd5,    1'b0, 1'b1, 1'b1, 1'b1, 11'd18};
    vecs[3]  = '{1'b0, 1'b1, 11'd500,  11'd2000, 1'b0, 1'b1, 1'b1, 1'b1, 11'd1472};
    vecs[4]  = '{1'b1, 1'b1, 11'd17,   11'd300,  1'b1, 1'b0, 1'b1, 1'b0, 11'd18};
    vecs[5]  = '{1'b1, 1'b0, 11'd18,   11'd0,    1'b1, 1'b0, 1'b1, 1'b0, 11'd18};
    vecs[6]  = '{1'b0, 1'b1, 11'd0,    11'd1472, 1'b0, 1'b1, 1'b1, 1'b1, 11'd1472};
    vecs[7]  = '{1'b0, 1'b1, 11'd0,    11'd1473, 1'b0, 1'b1, 1'b1, 1'b1, 11'd1472};
    vecs[8]  = '{1'b1, 1'b0, 11'd0,    11'd700,  1'b1, 1'b0, 1'b1, 1'b0, 11'd18};
    vecs[9]  = '{1'b1, 1'b0, 11'd2047, 11'd0,    1'b1, 1'b0, 1'b1, 1'b0, 11'd1472};
    vecs[10] = '{1'b0, 1'b1, 11'd0,    11'd19,   1'b0, 1'b1, 1'b1, 1'b1, 11'd19};

    step(2);
    checkOutput("resetOutputs",
                {30'd0, tx_start, tx_len, tx_sel, gnt0, gnt1, done0, done1, tx_err, frames_sent}, 64'd0);

    for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

    // Single request with a 500-cycle frame
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0 = 1'b1;
    len0 = 11'd100;
    step();
    checkOutput("singleGrant", {gnt0, gnt1, tx_start, tx_sel, tx_len}, {1'b1, 1'b0, 1'b1, 1'b0, 11'd100});
    req0 = 1'b0;
    len0 = 11'h7FF;
    runFrame(500, d, stray);
    checkOutput("singleNoEarlyPulse", {63'd0, stray}, 64'd0);
    checkOutput("singleDone", {done0, done1, frames_sent}, {1'b1, 1'b0, 16'd1});
    checkOutput("singleStable", {tx_sel, tx_len}, {1'b0, 11'd100});
    step();
    checkOutput("singleDoneOnePulse", {62'd0, done0, done1}, 64'd0);

    // Tie after reset alternates 0,1,0,1 with a full gap between frames
    reset = 1'b1;
    step();
    reset = 1'b0;
    req0 = 1'b1;
    req1 = 1'b1;
    prevDone = 0;
    for (int r = 0; r < 4; r++) begin
      waitStart(400, s);
      checkOutput($sformatf("tieGrant%0d", r), {62'd0, gnt0, gnt1},
                  (r % 2 == 0) ? 64'd2 : 64'd1);
      if (r > 0) checkOutput($sformatf("tieSpacing%0d", r), 64'(s - prevDone), 64'(IPG + 1));
      runFrame(20, d, stray);
      checkOutput($sformatf("tieDone%0d", r), {62'd0, done0, done1},
                  (r % 2 == 0) ? 64'd2 : 64'd1);
      prevDone = d;
    end
    req0 = 1'b0;
    req1 = 1'b0;
    checkOutput("tieCount", {48'd0, frames_sent}, 64'd4);

    // Start timeout: transmitter never rises busy
    req1 = 1'b1;
    len1 = 11'd700;
    waitStart(400, s);
    checkOutput("tmoGrant", {gnt0, gnt1, tx_sel, tx_len}, {1'b0, 1'b1, 1'b1, 11'd700});
    req1 = 1'b0;
    errCnt = 0;
    errCyc = -1;
    anyDone = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (tx_err) begin
        errCnt++;
        errCyc = cyc;
      end
      anyDone = anyDone | done0 | done1;
    end
    checkOutput("tmoErrPulses", 64'(errCnt), 64'd1);
    checkOutput("tmoErrTiming", 64'(errCyc - s), 64'(TMO + 1));
    checkOutput("tmoNoDone", {63'd0, anyDone}, 64'd0);
    checkOutput("tmoCountHeld", {48'd0, frames_sent}, 64'd4);
    req0 = 1'b1;
    req1 = 1'b1;
    waitStart(400, s2);
    checkOutput("tmoNextGrant", {62'd0, gnt0, gnt1}, 64'd2);
    checkOutput("tmoNextSpacing", 64'(s2 - errCyc), 64'(IPG + 1));

    // Reset during SENDING, then a tie goes to req0 again
    step();
    tx_busy = 1'b1;
    step(5);
    reset = 1'b1;
    step();
    checkOutput("midResetOutputs",
                {30'd0, tx_start, tx_len, tx_sel, gnt0, gnt1, done0, done1, tx_err, frames_sent}, 64'd0);
    reset = 1'b0;
    step();
    checkOutput("postResetTie", {61'd0, gnt0, gnt1, tx_start}, 64'd5);
    req0 = 1'b0;
    req1 = 1'b0;
    step(4);
    tx_busy = 1'b0;
    step();
    checkOutput("postResetDone", {done0, done1, frames_sent}, {1'b1, 1'b0, 16'd1});

    // Counter wrap from a preloaded 16'hFFFF
    force dut.frameCnt_q = 16'hFFFF;
    step();
    release dut.frameCnt_q;
    step();
    checkOutput("wrapPreload", {48'd0, frames_sent}, 64'hFFFF);
    req1 = 1'b1;
    len1 = 11'd64;
    waitStart(400, s);
    req1 = 1'b0;
    runFrame(10, d, stray);
    checkOutput("wrapDone", {done0, done1, frames_sent}, {1'b0, 1'b1, 16'd0});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
